// File: rtl/present_pkg.sv
// Shared PRESENT constants, FSM state type and the substitution/permutation
// layers used by the round datapath.
package present_pkg;

  localparam int BLOCK_W    = 64;
  localparam int NUM_ROUNDS = 31;
`ifdef KEY_128
  localparam int KEY_W      = 128;
`else
  localparam int KEY_W      = 80;
`endif

  // Nibble n of this word holds S(n).
  localparam logic [63:0] SBOX_TABLE = 64'h21748FE3DA09B65C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    return SBOX_TABLE[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [BLOCK_W-1:0] s_layer(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int n = 0; n < 16; n++) begin
      r[4*n +: 4] = sbox(s[4*n +: 4]);
    end
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) begin
      r[(16*i) % 63] = s[i];
    end
    r[63] = s[63];
    return r;
  endfunction

endpackage

// File: rtl/present_round.sv
// One PRESENT round without the counter or key logic: key mix, S-box, permute.
module present_round
  import present_pkg::*;
(
  input  logic [BLOCK_W-1:0] i_st,
  input  logic [BLOCK_W-1:0] i_rk,
  output logic [BLOCK_W-1:0] o_st
);

  assign o_st = p_layer(s_layer(i_st ^ i_rk));

endmodule

// File: rtl/present_round_engine.sv
// Iterative PRESENT encryption engine: one round per clock, round keys read
// combinationally from the scheduler's table through key_idx.
module present_round_engine
  import present_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               key_ready,
  output logic [4:0]         key_idx,
  input  logic [KEY_W-1:0]   round_key,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);

  state_t             r_state, w_state_nxt;
  logic [BLOCK_W-1:0] r_st, w_st_nxt;
  logic [BLOCK_W-1:0] r_out_data, w_out_data_nxt;
  logic [4:0]         r_idx, w_idx_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic               r_busy, w_busy_nxt;
  logic [BLOCK_W-1:0] w_rk;
  logic [BLOCK_W-1:0] w_round_out;

  assign w_rk      = round_key[KEY_W-1 -: BLOCK_W];
  // r_idx is parked at 0 outside RUN, so it can drive key_idx directly.
  assign key_idx   = r_idx;
  assign in_ready  = (r_state == IDLE) && key_ready && !rst;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;

  present_round u_round (
    .i_st (r_st),
    .i_rk (w_rk),
    .o_st (w_round_out)
  );

  // Next-state and next-register values for the engine FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_st_nxt        = r_st;
    w_out_data_nxt  = r_out_data;
    w_idx_nxt       = r_idx;
    w_out_valid_nxt = r_out_valid;
    w_busy_nxt      = r_busy;
    case (r_state)
      IDLE: begin
        if (in_valid && in_ready) begin
          w_st_nxt    = in_data;
          w_idx_nxt   = 5'd0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (r_idx < 5'(NUM_ROUNDS)) begin
          w_st_nxt  = w_round_out;
          w_idx_nxt = r_idx + 5'd1;
        end else begin
          w_out_data_nxt  = r_st ^ w_rk;
          w_out_valid_nxt = 1'b1;
          w_busy_nxt      = 1'b0;
          w_idx_nxt       = 5'd0;
          w_state_nxt     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_idx_nxt       = 5'd0;
        w_state_nxt     = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_st        <= '0;
      r_out_data  <= '0;
      r_idx       <= 5'd0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_st        <= w_st_nxt;
      r_out_data  <= w_out_data_nxt;
      r_idx       <= w_idx_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

endmodule
